// File: rtl/riscv_custom_pkg.sv
// Shared types for the CEU GCD/divide engine: operation modes, error codes
// and the FSM state encoding.
package riscv_custom_pkg;

  typedef enum logic [1:0] {
    OP_GCD  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REMU = 2'd2,
    OP_RSVD = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_DBZ     = 2'd1,
    ERR_WDOG    = 2'd2,
    ERR_ILLEGAL = 2'd3
  } err_e;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_CHECK = 2'd1;
  localparam state_t S_DIV   = 2'd2;
  localparam state_t S_DONE  = 2'd3;

endpackage

// File: rtl/riscv_custom_gcd_div_if.sv
// Request/response bundle between the CEU pipeline and the GCD/divide engine.
interface riscv_custom_gcd_div_if #(
  parameter int WIDTH = 32
);
  import riscv_custom_pkg::*;

  // Handshake: a request is accepted on the rising edge where start_i && ready_o.
  // Every accepted request that is not killed produces exactly one done_o pulse;
  // result_o/err_o are valid from that cycle and held until the next done_o.
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] operand_a_i;
  logic [WIDTH-1:0] operand_b_i;
  logic             kill_i;
  logic             ready_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;
  logic [1:0]       err_o;
  state_t           state_dbg;

  modport master (
    output start_i, op_i, operand_a_i, operand_b_i, kill_i,
    input  ready_o, done_o, result_o, err_o, state_dbg
  );

  modport slave (
    input  start_i, op_i, operand_a_i, operand_b_i, kill_i,
    output ready_o, done_o, result_o, err_o, state_dbg
  );

endinterface

// File: rtl/riscv_custom_divstep.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module riscv_custom_divstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             quot_bit
);

  logic [WIDTH:0] trial;

  assign trial    = {rem, dividend_bit};
  assign quot_bit = (trial >= {1'b0, divisor});
  // The partial remainder stays below the divisor, so WIDTH bits always hold it.
  assign rem_next = quot_bit ? WIDTH'(trial - {1'b0, divisor}) : WIDTH'(trial);

endmodule

// File: rtl/riscv_custom_gcd_div.sv
// Multi-cycle unsigned GCD / DIVU / REMU engine built around one shared
// restoring-division step; GCD runs Euclid rounds through the same datapath.
module riscv_custom_gcd_div #(
  parameter int WIDTH    = 32,
  parameter int MAX_ITER = 64
) (
  input logic                   clk,
  input logic                   rst,
  riscv_custom_gcd_div_if.slave bus
);
  import riscv_custom_pkg::*;

  localparam int CNT_W  = $clog2(WIDTH) + 1;
  localparam int IDX_W  = $clog2(WIDTH);
  localparam int ITER_W = $clog2(MAX_ITER + 1);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(WIDTH);
  localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);

  state_t            state_q;
  op_e               op_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  rem_q;
  logic [WIDTH-1:0]  quot_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ITER_W-1:0] iter_q;
  logic              done_q;
  logic [WIDTH-1:0]  result_q;
  err_e              err_q;

  logic [IDX_W-1:0]  bit_idx;
  logic              step_bit;
  logic              step_q;
  logic [WIDTH-1:0]  step_rem;
  logic [WIDTH-1:0]  quot_next;

  // cnt counts WIDTH..1, so the bit under the step is a[cnt-1], MSB first.
  assign bit_idx   = IDX_W'(cnt_q - CNT_W'(1));
  assign step_bit  = a_q[bit_idx];
  assign quot_next = quot_q | (WIDTH'(step_q) << bit_idx);

  riscv_custom_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem          (rem_q),
    .dividend_bit (step_bit),
    .divisor      (b_q),
    .rem_next     (step_rem),
    .quot_bit     (step_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_GCD;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      cnt_q    <= '0;
      iter_q   <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      err_q    <= ERR_NONE;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start_i) begin
            op_q   <= op_e'(bus.op_i);
            iter_q <= '0;
            // GCD starts with the larger operand as the dividend.
            if (op_e'(bus.op_i) == OP_GCD && bus.operand_a_i < bus.operand_b_i) begin
              a_q <= bus.operand_b_i;
              b_q <= bus.operand_a_i;
            end else begin
              a_q <= bus.operand_a_i;
              b_q <= bus.operand_b_i;
            end
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (bus.kill_i) begin
            state_q <= S_IDLE;
          end else if (op_q == OP_RSVD) begin
            state_q  <= S_DONE;
            done_q   <= 1'b1;
            result_q <= '0;
            err_q    <= ERR_ILLEGAL;
          end else if (b_q == '0) begin
            state_q  <= S_DONE;
            done_q   <= 1'b1;
            result_q <= (op_q == OP_DIVU) ? '1 : a_q;
            err_q    <= (op_q == OP_GCD) ? ERR_NONE : ERR_DBZ;
          end else if (op_q == OP_GCD && iter_q == ITER_MAX) begin
            state_q  <= S_DONE;
            done_q   <= 1'b1;
            result_q <= a_q;
            err_q    <= ERR_WDOG;
          end else begin
            rem_q   <= '0;
            quot_q  <= '0;
            cnt_q   <= CNT_INIT;
            iter_q  <= iter_q + ITER_W'(1);
            state_q <= S_DIV;
          end
        end
        S_DIV: begin
          if (bus.kill_i) begin
            state_q <= S_IDLE;
          end else begin
            rem_q  <= step_rem;
            quot_q <= quot_next;
            cnt_q  <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              if (op_q == OP_GCD) begin
                a_q     <= b_q;
                b_q     <= step_rem;
                state_q <= S_CHECK;
              end else begin
                state_q  <= S_DONE;
                done_q   <= 1'b1;
                result_q <= (op_q == OP_DIVU) ? quot_next : step_rem;
                err_q    <= ERR_NONE;
              end
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ready_o   = (state_q == S_IDLE);
  assign bus.done_o    = done_q;
  assign bus.result_o  = result_q;
  assign bus.err_o     = err_q;
  assign bus.state_dbg = state_q;

endmodule

// File: doc/riscv_custom_gcd_div.md
# riscv_custom_gcd_div

Parametrised multi-cycle arithmetic engine for the custom execution unit (CEU). It computes unsigned GCD, quotient or remainder of two WIDTH-bit operands using one shared restoring-division datapath. It has a start/ready/done handshake, abort and error reporting. It sits behind the CEU result mux and stalls the pipeline through `ready_o`.

## Interface
- WIDTH, 32: operand/result width, ≥4.
- MAX_ITER, 64: maximum Euclid division rounds per GCD before the watchdog aborts.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  request; accepted on a rising edge where start_i=1 and ready_o=1.
- op_i  in  2  mode: 0=GCD, 1=DIVU (quotient), 2=REMU (remainder), 3=reserved.
- operand_a_i  in  WIDTH  dividend / first GCD operand; sampled at accept only.
- operand_b_i  in  WIDTH  divisor / second GCD operand; sampled at accept only.
- kill_i  in  1  abort of an in-flight operation.
- ready_o  out  1  high iff FSM is in IDLE.
- done_o  out  1  one-cycle completion pulse.
- result_o  out  WIDTH  result; valid from done_o and held until the next done_o.
- err_o  out  2  0=none, 1=divide-by-zero, 2=watchdog, 3=illegal op; updated with done_o.

## Operation
- States: IDLE, CHECK, DIV, DONE. Reset puts the FSM in IDLE with ready_o=1, done_o=0, result_o=0, err_o=0, and all internal registers at 0.
- On accept:
  - GCD: a=max(A,B), b=min(A,B).
  - DIV/REM: a=A, b=B.
  - iter=0; go to CHECK.
- CHECK, first matching rule applies:
  - op=3 → DONE, result 0, err 3.
  - b==0:
    - GCD → DONE, result a, err 0.
    - DIVU → DONE, result all-ones, err 1.
    - REMU → DONE, result a, err 1.
  - GCD and iter==MAX_ITER → DONE, result a, err 2.
  - Otherwise clear rem/quot, cnt=WIDTH, iter++ → DIV.
- DIV runs one restoring step per cycle, MSB of a first:
  - t={rem,a[cnt-1]}, WIDTH+1 bits.
  - If t≥b: rem=t−b and the quotient bit is 1; else rem=t.
  - cnt decrements each step.
  - After the step with cnt==1:
    - DIVU → DONE with result quotient.
    - REMU → DONE with result rem.
    - GCD → a=b, b=rem, back to CHECK.
- DONE: done_o=1 for exactly this cycle, result_o/err_o take their new values, next state IDLE.
- kill_i in CHECK or DIV: next state IDLE, no done_o, result_o/err_o unchanged. kill_i in IDLE or DONE has no effect.
- start_i while not ready is ignored. Operand changes after accept have no effect.
- rst mid-operation: outputs return to reset values immediately (asynchronous).

## Timing
- The accepting edge is cycle 0; CHECK is cycle 1.
- DIVU/REMU with b≠0: DIV occupies cycles 2..WIDTH+1; done_o is high in cycle WIDTH+2 (34 for WIDTH=32).
- GCD needing k divisions: done_o is high in cycle k·WIDTH + k + 2.
- Zero divisor, GCD with b=0, illegal op: done_o is high in cycle 2.
- ready_o falls in cycle 1 and rises in the cycle after DONE. The earliest back-to-back accept is the edge that ends the DONE cycle + 1.
- No combinational path from any input to any output, except ready_o derived from state.

## Structure
- Shared package riscv_custom_pkg holds:
  - the mode enum (GCD/DIVU/REMU/RSVD);
  - the error enum (NONE/DBZ/WDOG/ILLEGAL);
  - the FSM state typedef.
- Sub-module riscv_custom_divstep, combinational: inputs rem, next dividend bit, divisor; outputs new rem and quotient bit. Its width is WIDTH+1 internally.
- Counters:
  - cnt: $clog2(WIDTH)+1 bits.
  - iter: $clog2(MAX_ITER+1) bits.

## Test plan
- DIVU 100/7, WIDTH=32 → done_o in cycle 34, result 14, err 0. REMU 100/7 → result 2.
- GCD(48,18) → 3 divisions, done_o in cycle 101, result 6. GCD(18,48) gives the same result and cycle. GCD(0,0) → cycle 2, result 0.
- DIVU 5/0 → cycle 2, result 0xFFFFFFFF, err 1. REMU 5/0 → result 5, err 1. op=3 → result 0, err 3.
- MAX_ITER=2, GCD(48,18) → done_o in cycle 68, result 12, err 2.
- kill_i in cycle 10 of DIVU → no done_o, ready_o high in cycle 11, previous result_o held. A new DIVU 9/3 then returns 3.
- rst asserted mid-GCD → ready_o=1, done_o=0, result_o=0, err_o=0 without waiting for a clock edge. Also: start_i held high through a whole operation → only one operation runs; the next is accepted after DONE.
